// File: rtl/ras_pkg.sv
// Shared types for the JALR return-address stack: link-register constants,
// the stack operation encoding and the link-register test.
package ras_pkg;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_POPPUSH = 2'd3
  } ras_op_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_op_decode.sv
// Maps a decoded JAL/JALR to a return-address-stack operation.
// Purely combinational, zero latency; no flow control.
module ras_op_decode
  import ras_pkg::*;
(
  input  logic       inst_valid,
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  output ras_op_t    op
);

  logic rd_link;
  logic rs1_link;

  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  always_comb begin
    op = RAS_NONE;
    if (inst_valid) begin
      if (is_jal) begin
        if (rd_link) op = RAS_PUSH;
      end else if (is_jalr) begin
        // Coroutine swap (both link, different regs) replaces the top entry.
        if (rd_link && rs1_link && (rd != rs1)) op = RAS_POPPUSH;
        else if (rd_link)                       op = RAS_PUSH;
        else if (rs1_link)                      op = RAS_POP;
      end
    end
  end

endmodule

// File: rtl/ras_jalr_predictor.sv
// Circular return-address stack with one checkpoint; predicts JALR return targets.
// Updates land at the clock edge and are visible right after it; no backpressure.
module ras_jalr_predictor
  import ras_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [31:0]      pc,
  input  logic             ckpt_save,
  input  logic             ckpt_restore,
  output logic [31:0]      pred_target,
  output logic             pred_valid,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  ras_op_t op;

  logic [31:0]      entry_q [DEPTH];
  logic [31:0]      entry_d [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] snap_tos_q, snap_tos_d;
  logic [PTR_W:0]   snap_count_q, snap_count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [31:0]      push_val;
  logic [PTR_W-1:0] tos_inc;

  ras_op_decode u_decode (
    .inst_valid (inst_valid),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .rd         (rd),
    .rs1        (rs1),
    .op         (op)
  );

  assign push_val = pc + 32'd4;
  assign tos_inc  = tos_q + PTR_ONE;

  always_comb begin
    entry_d      = entry_q;
    tos_d        = tos_q;
    count_d      = count_q;
    snap_tos_d   = snap_tos_q;
    snap_count_d = snap_count_q;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;

    // Restore discards both the decoded action and any simultaneous save.
    if (ckpt_restore) begin
      tos_d   = snap_tos_q;
      count_d = snap_count_q;
    end else begin
      if (ckpt_save) begin
        snap_tos_d   = tos_q;
        snap_count_d = count_q;
      end
      unique case (op)
        RAS_PUSH: begin
          tos_d          = tos_inc;
          entry_d[tos_inc] = push_val;
          if (count_q == FULL) overflow_d = 1'b1;
          else                 count_d    = count_q + CNT_ONE;
        end
        RAS_POP: begin
          if (count_q == '0) begin
            underflow_d = 1'b1;
          end else begin
            tos_d   = tos_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
          end
        end
        RAS_POPPUSH: begin
          if (count_q == '0) begin
            tos_d            = tos_inc;
            entry_d[tos_inc] = push_val;
            count_d          = CNT_ONE;
          end else begin
            entry_d[tos_q] = push_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      tos_q        <= '0;
      count_q      <= '0;
      snap_tos_q   <= '0;
      snap_count_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      tos_q        <= tos_d;
      count_q      <= count_d;
      snap_tos_q   <= snap_tos_d;
      snap_count_q <= snap_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign pred_target = entry_q[tos_q];
  assign pred_valid  = (count_q != '0);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: doc/ras_jalr_predictor.md
Name: ras_jalr_predictor

Overview:
- Return-address stack (RAS) that predicts the target of a JALR return before rs1 is read in the RISC-V core's fetch/decode path.
- Pushes the link address (PC+4) on calls and pops on returns.
- Provides the predicted return target that the JALR target-select path consumes, together with a validity flag.
- Sits beside decode and supports a single checkpoint/restore for branch-mispredict recovery.

Parameters:
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), width of the top-of-stack pointer.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst_valid  input  1  qualifies is_jal, is_jalr, rd, rs1 and pc for this cycle.
- is_jal  input  1  decoded instruction is JAL.
- is_jalr  input  1  decoded instruction is JALR.
- rd  input  5  destination register index.
- rs1  input  5  source register index; meaningful only when is_jalr is 1.
- pc  input  32  address of the decoded instruction.
- ckpt_save  input  1  snapshot tos_ptr and count.
- ckpt_restore  input  1  reload tos_ptr and count from the snapshot.
- pred_target  output  32  entry at top of stack.
- pred_valid  output  1  1 when count != 0.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- overflow  output  1  one-cycle pulse: a push overwrote the oldest entry.
- underflow  output  1  one-cycle pulse: a pop was attempted on an empty stack.

Behaviour:
- Reset (asynchronous, rst=1): tos_ptr=0, count=0, snapshot cleared, all entries=0, pred_target=0, pred_valid=0, overflow=0, underflow=0.
- Link test: link(r) is true for r==1 or r==5.
- Action decode (only when inst_valid=1; JAL and JALR are mutually exclusive, so is_jal and is_jalr are never both 1):
  - is_jal, link(rd) -> PUSH.
  - is_jalr, !link(rd), link(rs1) -> POP.
  - is_jalr, link(rd), !link(rs1) -> PUSH.
  - is_jalr, link(rd), link(rs1), rd!=rs1 -> POP_THEN_PUSH (replace top).
  - is_jalr, link(rd), link(rs1), rd==rs1 -> PUSH.
  - Anything else -> NONE.
- Push value is pc+4, computed modulo 2^32 (pc=32'hFFFF_FFFC pushes 0).
- PUSH: tos_ptr <= tos_ptr+1 (wraps mod DEPTH); entry[new tos] <= pc+4; count <= min(count+1, DEPTH); overflow pulses if count was already DEPTH.
- POP: if count>0, tos_ptr <= tos_ptr-1 (wraps) and count-1. If count==0, state is unchanged and underflow pulses.
- POP_THEN_PUSH: entry[tos_ptr] <= pc+4; pointer and count are unchanged. If count was 0, it behaves as PUSH (count becomes 1) and no underflow pulses.
- pred_target = entry[tos_ptr] and pred_valid = (count!=0), both driven from registered state.
- Latency: an update at edge N is visible on the outputs immediately after edge N. A return decoded in the same cycle as the preceding push sees the pre-push top.
- Checkpoint:
  - ckpt_save stores {tos_ptr, count}; entry contents are not saved.
  - ckpt_restore reloads them at the next edge and takes priority over any action that cycle; the action is discarded.
  - ckpt_save together with ckpt_restore: the restore wins and the snapshot is unchanged.
- overflow and underflow are deasserted every cycle they are not pulsed.
- rst asserted mid-operation clears all state immediately; the first edge after deassert is treated as the first operating edge.

Decomposition:
- Shared package ras_pkg:
  - LINK_X1=5'd1 and LINK_X5=5'd5.
  - enum ras_op_t {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}.
  - Function is_link(r).
- One combinational sub-module, ras_op_decode, maps (inst_valid, is_jal, is_jalr, rd, rs1) to ras_op_t.
- The stack array, pointer and checkpoint logic stay in ras_jalr_predictor.

Test Plan:
- Reset, then JAL rd=1 at pc=0x100 -> next cycle pred_target=0x104, pred_valid=1, count=1. JALR rd=0 rs1=1 -> count=0, pred_valid=0, no underflow pulse.
- Nested calls at pc=0x10,0x20,0x30 -> pred_target is 0x34, then 0x24, then 0x14 across three returns; a fourth return pulses underflow=1 with count staying 0.
- DEPTH+1 pushes with pc=0x1000+4*i, i=0..8 -> overflow pulses on the 9th push, count=8; the next 8 pops return 0x1024 down to 0x1008, and pred_valid=0 after the 8th pop.
- With count=2 and top=0x44, JALR rd=1 rs1=5 at pc=0x200 -> pred_target=0x204, count=2, no flags. Then JALR rd=1 rs1=1 -> count=3.
- ckpt_save at count=2, then 2 pushes and 1 pop, then ckpt_restore together with a JAL rd=1 -> count=2, the JAL is ignored, pred_target equals the top at save time.
- Assert rst in the cycle after a push -> all outputs are 0 asynchronously, before the next clock edge.
